char_font_loader: RTL and testbench
===================================

# char_font_loader

Writer for the character-generator font memory. It accepts a byte stream (MiSTer download or CPU port) over a valid/ready handshake and writes it into the write port of the dual-port font RAM that the character generator reads. The font RAM is organised as 256 glyphs x 16 rows at address {char_code, row}. After loading, the block optionally reads the whole RAM back and compares a checksum to confirm the upload. It sits between the download/IO mux and the font RAM, in the pixel clock domain.

## Interface
- DEPTH, 4096: bytes per full font load; power of two; address width is log2(DEPTH).
- REVERSE, 1: when 1, each byte's bit order is reversed before it is stored. Host supplies MSB = leftmost pixel; the stored format is the generator's LSB-leftmost format.
- VERIFY, 1: when 1, a readback checksum pass runs after the load.

Ports:
- pixel_clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; ignored unless the state is IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- dl_data  in  8  stream byte.
- dl_valid  in  1  dl_data is valid.
- dl_ready  out  1  combinational; equals (state==LOAD).
- ram_addr  out  12  registered RAM address (write and read).
- ram_wdata  out  8  registered write data.
- ram_we  out  1  registered write strobe.
- ram_rdata  in  8  RAM read data; synchronous RAM with one-clock latency.
- busy  out  1  high in LOAD, VRD, VCMP.
- done  out  1  sticky; set on completion and cleared by start.
- error  out  1  sticky; set on checksum mismatch and cleared by start.

## Operation
- States: IDLE, LOAD, VRD, VCMP.
- IDLE, start=1:
  - clear the byte counter, sum_w, sum_r, done and error;
  - go to LOAD.
- LOAD, one byte accepted per cycle with dl_valid&dl_ready:
  - b = REVERSE ? bitrev(dl_data) : dl_data;
  - next edge: ram_we=1, ram_addr=count, ram_wdata=b;
  - sum_w += b (16-bit, wraps mod 2^16);
  - count++.
- A cycle with dl_valid=0 leaves ram_we=0 and holds count. Gaps are allowed anywhere.
- Accepting the byte with count==DEPTH-1 ends the load:
  - VERIFY=1: go to VRD with count=0;
  - VERIFY=0: set done and go to IDLE.
- VRD:
  - ram_we=0; ram_addr=count, count++ each cycle until DEPTH-1;
  - a 1-bit valid pipeline tags returned data; each tagged ram_rdata adds into sum_r (16-bit wrap);
  - after the last address is issued, go to VCMP.
- VCMP:
  - wait until the final tagged byte has been summed;
  - compare sum_r with sum_w and set error on mismatch;
  - set done in all cases;
  - go to IDLE.
- abort in any state:
  - next edge: state=IDLE, ram_we=0;
  - done and error keep their old values;
  - RAM contents already written stay written.
- start while busy is ignored. dl_valid while not in LOAD is not accepted (dl_ready=0).
- Simultaneous abort and start in IDLE: abort wins and the state stays IDLE.
- ram_addr wraps naturally. count never exceeds DEPTH-1 because the state changes on the last byte.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - state=IDLE, dl_ready=0;
  - ram_addr=0, ram_wdata=0, ram_we=0;
  - busy=0, done=0, error=0;
  - count=0, sums=0.
- start at edge k: LOAD and dl_ready=1 from edge k+1.
- Handshake at edge n: ram_we/addr/wdata valid during cycle n+1, for exactly one cycle per byte.
- Load of DEPTH bytes with no gaps: DEPTH cycles of dl_ready.
- Readback latency:
  - ram_addr driven from edge m is sampled by the RAM at edge m+1;
  - the loader sums ram_rdata at edge m+2.
- Verify duration: DEPTH cycles in VRD plus 2 cycles in VCMP.
- done/error update on the VCMP exit edge, when busy also falls.
- Total time from start to done for an ungapped stream with VERIFY=1 is DEPTH+DEPTH+3 cycles.

## Test plan
- Ramp load:
  - stimulus: start, then bytes i&0xFF for i=0..4095 with no gaps, REVERSE=0;
  - required: RAM[i]==i&0xFF, exactly 4096 ram_we pulses, done=1, error=0, busy low after 8195 cycles.
- Bit reversal:
  - stimulus: REVERSE=1, byte 0x80 to address 0 and 0x3C to address 1;
  - required: RAM[0]==0x01, RAM[1]==0x3C; byte 0x12 stores 0x48.
- Backpressure gaps:
  - stimulus: random dl_valid duty of 30%;
  - required: no duplicated or skipped addresses, final contents identical to the ramp case.
- Verify failure:
  - stimulus: the bench model flips RAM[0x7FF] bit 0 before VRD;
  - required: done=1, error=1; a new start clears both.
- Abort at count=100:
  - stimulus: abort asserted mid-load;
  - required: IDLE next cycle, dl_ready=0, no further ram_we, done/error unchanged.
- Reset mid-VRD, plus start while busy:
  - stimulus: reset_n pulsed low during VRD; separately, start asserted during LOAD;
  - required: all outputs at reset values immediately on reset; the start during LOAD has no effect on count.

Source files
------------

// File: rtl/char_font_loader.sv
// Font RAM writer: streams DEPTH bytes into the glyph RAM over valid/ready,
// then optionally reads the RAM back and compares a 16-bit checksum.
module char_font_loader #(
  parameter int DEPTH   = 4096,
  parameter bit REVERSE = 1'b1,
  parameter bit VERIFY  = 1'b1
) (
  input  logic                     pixel_clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               dl_data,
  input  logic                     dl_valid,
  output logic                     dl_ready,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [7:0]               ram_wdata,
  output logic                     ram_we,
  input  logic [7:0]               ram_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, VRD, VCMP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   count_q, count_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [15:0]     sum_w_q, sum_w_d;
  logic [15:0]     sum_r_q, sum_r_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            vld1_q, vld1_d;
  logic            vld2_q, vld2_d;
  logic [7:0]      byte_in;

  function automatic logic [7:0] bitrev(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Host sends MSB-leftmost; the generator expects LSB-leftmost.
  assign byte_in = REVERSE ? bitrev(dl_data) : dl_data;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    sum_w_d = sum_w_q;
    sum_r_d = sum_r_q;
    done_d  = done_q;
    error_d = error_q;
    vld1_d  = 1'b0;
    vld2_d  = vld1_q;
    // vld1 marks an address issued last edge, vld2 marks its data on ram_rdata now.
    if (vld2_q) sum_r_d = sum_r_q + {8'd0, ram_rdata};
    if (abort) begin
      state_d = IDLE;
      vld2_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          count_d = '0;
          sum_w_d = '0;
          sum_r_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = LOAD;
        end
        LOAD: if (dl_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q;
          wdata_d = byte_in;
          sum_w_d = sum_w_q + {8'd0, byte_in};
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            count_d = '0;
            if (VERIFY) begin
              state_d = VRD;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        VRD: begin
          addr_d  = count_q;
          vld1_d  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            count_d = '0;
            state_d = VCMP;
          end
        end
        VCMP: if (vld2_q && !vld1_q) begin
          // The last byte is summed on this very edge, so compare the updated sum.
          error_d = (sum_r_d != sum_w_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sum_w_q <= '0;
      sum_r_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sum_w_q <= sum_w_d;
      sum_r_q <= sum_r_d;
      done_q  <= done_d;
      error_q <= error_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
    end
  end

  assign dl_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_char_font_loader.sv
// Bench for char_font_loader: behavioural font RAMs, write scoreboard and
// directed load / verify / abort / reset scenarios.
module tb_char_font_loader;

  localparam int DEPTH = 4096;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        pixelClock = 1'b0;
  logic        resetN = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  dlData = 8'h00;
  logic        dlValid = 1'b0;
  logic        dlReady, ramWe, busy, done, error;
  logic [11:0] ramAddr;
  logic [7:0]  ramWdata, ramRdata;
  logic        revReady, revWe, revBusy, revDone, revError;
  logic [11:0] revAddr;
  logic [7:0]  revWdata, revRdata;
  logic [7:0]  mem [0:DEPTH-1];
  logic [7:0]  memRev [0:DEPTH-1];
  logic        corrupt = 1'b0;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount = 0;
  int   wePulses = 0;
  int   cycleCnt = 0;

  char_font_loader #(.DEPTH(DEPTH), .REVERSE(1'b0), .VERIFY(1'b1)) dut (
    .pixel_clock(pixelClock), .reset_n(resetN), .start(start), .abort(abort),
    .dl_data(dlData), .dl_valid(dlValid), .dl_ready(dlReady),
    .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_we(ramWe), .ram_rdata(ramRdata),
    .busy(busy), .done(done), .error(error)
  );

  char_font_loader #(.DEPTH(DEPTH), .REVERSE(1'b1), .VERIFY(1'b1)) dutRev (
    .pixel_clock(pixelClock), .reset_n(resetN), .start(start), .abort(abort),
    .dl_data(dlData), .dl_valid(dlValid), .dl_ready(revReady),
    .ram_addr(revAddr), .ram_wdata(revWdata), .ram_we(revWe), .ram_rdata(revRdata),
    .busy(revBusy), .done(revDone), .error(revError)
  );

  always #5 pixelClock = ~pixelClock;

  // Synchronous font RAMs; 'corrupt' models a flipped bit 0 at 0x7FF on readback.
  always @(posedge pixelClock) begin
    if (ramWe) mem[ramAddr] <= ramWdata;
    ramRdata <= mem[ramAddr] ^ ((corrupt && ramAddr == 12'h7FF) ? 8'h01 : 8'h00);
  end

  always @(posedge pixelClock) begin
    if (revWe) memRev[revAddr] <= revWdata;
    revRdata <= memRev[revAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] byteFor(input int pattern, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (pattern == 1 && i == 0) b = 8'h80;
    if (pattern == 1 && i == 1) b = 8'h3C;
    if (pattern == 1 && i == 2) b = 8'h12;
    return b;
  endfunction

  // Drives nBytes of a pattern at the given valid duty; optionally pulses start at byte startAt.
  task automatic applyStimulus(input int pattern, input int dutyPct, input int nBytes, input int startAt);
    int i;
    logic [7:0] b;
    i = 0;
    while (i < nBytes) begin
      @(negedge pixelClock);
      b = byteFor(pattern, i);
      dlValid = ($urandom_range(99, 0) < 32'(dutyPct));
      dlData = b;
      start = (i == startAt);
      if (dlValid) begin
        checkOutput("dl_ready", {31'd0, dlReady}, 32'd1);
        expQ.push_back('{addr: 12'(i), data: b});
        i++;
      end
    end
    @(negedge pixelClock);
    dlValid = 1'b0;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag, output int endCycle);
    int n;
    n = 0;
    do begin
      @(negedge pixelClock);
      n++;
    end while (busy && n < 3 * DEPTH);
    if (busy) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
    endCycle = cycleCnt;
  endtask

  task automatic checkRampMem(input string tag);
    for (int i = 0; i < DEPTH; i++) checkOutput(tag, {24'd0, mem[i]}, i & 32'hFF);
  endtask

  initial forever begin
    @(posedge pixelClock);
    cycleCnt++;
  end

  // Every write strobe must match the oldest accepted byte, in order, exactly once.
  initial forever begin
    exp_t e;
    @(negedge pixelClock);
    if (ramWe) begin
      wePulses++;
      if (expQ.size() == 0) begin
        checkOutput("we_spurious", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("we_addr", {20'd0, ramAddr}, {20'd0, e.addr});
        checkOutput("we_data", {24'd0, ramWdata}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #2_000_000;
    failCount++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCyc, endCyc, weBase;

    #2 resetN = 1'b0;
    #10;
    checkOutput("rst_ready", {31'd0, dlReady}, 32'd0);
    checkOutput("rst_addr", {20'd0, ramAddr}, 32'd0);
    checkOutput("rst_wdata", {24'd0, ramWdata}, 32'd0);
    checkOutput("rst_we", {31'd0, ramWe}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    @(negedge pixelClock);
    resetN = 1'b1;

    $display("[TB] ramp load");
    @(negedge pixelClock);
    start = 1'b1;
    startCyc = cycleCnt;
    weBase = wePulses;
    applyStimulus(0, 100, DEPTH, -1);
    waitIdle("ramp", endCyc);
    checkOutput("ramp_cycles", endCyc - startCyc, 32'd8195);
    checkOutput("ramp_we_pulses", wePulses - weBase, DEPTH);
    checkOutput("ramp_done", {31'd0, done}, 32'd1);
    checkOutput("ramp_error", {31'd0, error}, 32'd0);
    checkOutput("ramp_queue", expQ.size(), 32'd0);
    checkRampMem("ramp_mem");

    $display("[TB] bit reversal");
    @(negedge pixelClock);
    start = 1'b1;
    applyStimulus(1, 100, DEPTH, -1);
    waitIdle("rev", endCyc);
    checkOutput("rev_mem0", {24'd0, memRev[0]}, 32'h01);
    checkOutput("rev_mem1", {24'd0, memRev[1]}, 32'h3C);
    checkOutput("rev_mem2", {24'd0, memRev[2]}, 32'h48);
    checkOutput("rev_done", {31'd0, revDone}, 32'd1);
    checkOutput("rev_error", {31'd0, revError}, 32'd0);
    checkOutput("norev_mem0", {24'd0, mem[0]}, 32'h80);
    checkOutput("norev_mem2", {24'd0, mem[2]}, 32'h12);

    $display("[TB] backpressure gaps");
    @(negedge pixelClock);
    start = 1'b1;
    weBase = wePulses;
    applyStimulus(0, 30, DEPTH, -1);
    waitIdle("gap", endCyc);
    checkOutput("gap_we_pulses", wePulses - weBase, DEPTH);
    checkOutput("gap_done", {31'd0, done}, 32'd1);
    checkOutput("gap_error", {31'd0, error}, 32'd0);
    checkRampMem("gap_mem");

    $display("[TB] verify failure");
    @(negedge pixelClock);
    start = 1'b1;
    corrupt = 1'b1;
    applyStimulus(0, 100, DEPTH, -1);
    waitIdle("vfail", endCyc);
    corrupt = 1'b0;
    checkOutput("vfail_done", {31'd0, done}, 32'd1);
    checkOutput("vfail_error", {31'd0, error}, 32'd1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge pixelClock);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abortstart_busy", {31'd0, busy}, 32'd0);
    checkOutput("abortstart_ready", {31'd0, dlReady}, 32'd0);
    checkOutput("abortstart_done", {31'd0, done}, 32'd1);
    checkOutput("abortstart_error", {31'd0, error}, 32'd1);
    start = 1'b1;
    @(negedge pixelClock);
    start = 1'b0;
    checkOutput("restart_done", {31'd0, done}, 32'd0);
    checkOutput("restart_error", {31'd0, error}, 32'd0);
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);

    $display("[TB] abort at count 100");
    applyStimulus(0, 100, 100, -1);
    abort = 1'b1;
    dlValid = 1'b1;
    dlData = 8'hAA;
    @(posedge pixelClock);
    #1;
    weBase = wePulses;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, dlReady}, 32'd0);
    checkOutput("abort_we", {31'd0, ramWe}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_error", {31'd0, error}, 32'd0);
    @(negedge pixelClock);
    abort = 1'b0;
    repeat (10) @(negedge pixelClock);
    dlValid = 1'b0;
    checkOutput("abort_no_we", wePulses - weBase, 32'd0);
    checkOutput("abort_queue", expQ.size(), 32'd0);

    $display("[TB] start while busy, reset mid-verify");
    @(negedge pixelClock);
    start = 1'b1;
    applyStimulus(0, 100, DEPTH, 50);
    checkOutput("vrd_busy", {31'd0, busy}, 32'd1);
    repeat (100) @(negedge pixelClock);
    checkOutput("vrd_queue", expQ.size(), 32'd0);
    #2 resetN = 1'b0;
    #1;
    checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mrst_ready", {31'd0, dlReady}, 32'd0);
    checkOutput("mrst_addr", {20'd0, ramAddr}, 32'd0);
    checkOutput("mrst_wdata", {24'd0, ramWdata}, 32'd0);
    checkOutput("mrst_we", {31'd0, ramWe}, 32'd0);
    checkOutput("mrst_done", {31'd0, done}, 32'd0);
    checkOutput("mrst_error", {31'd0, error}, 32'd0);
    checkOutput("mrst_rev_busy", {31'd0, revBusy}, 32'd0);
    checkOutput("mrst_rev_ready", {31'd0, revReady}, 32'd0);
    @(negedge pixelClock);
    resetN = 1'b1;
    repeat (3) @(negedge pixelClock);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    checkRampMem("busystart_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
